// File: rtl/lfsr_pkg.sv
// Shared constants for the lfsr_gen family: default feedback masks and seeds per width,
// plus the width of the optional period counter.
package lfsr_pkg;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'h1D;
  localparam logic [15:0] LFSR_TAPS_16 = 16'h002D;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h0000_00C5;

  localparam logic [7:0]  LFSR_SEED_8  = 8'h01;
  localparam logic [15:0] LFSR_SEED_16 = 16'h0001;
  localparam logic [31:0] LFSR_SEED_32 = 32'h0000_0001;

  localparam int unsigned PERIOD_W = 32;

endpackage

// File: rtl/lfsr_step.sv
// Combinational Fibonacci LFSR advance: applies STEPS right-shifts, each feeding
// the XOR of the tapped bits back into the MSB.
module lfsr_step #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
  parameter int unsigned      STEPS = 1
) (
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] s;

  always_comb begin
    s = q;
    for (int i = 0; i < int'(STEPS); i++) begin
      s = {^(s & TAPS), s[WIDTH-1:1]};
    end
    q_next = s;
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load and all-zero lockup recovery.
// Define LFSR_PERIOD_CNT_EN to add the step counter (period) and return-to-start pulse (wrap).
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_8,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED_8,
  parameter int unsigned      STEPS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    init,
  input  logic                load,
  input  logic                en,
  output logic [WIDTH-1:0]    data,
  output logic                lockup,
  output logic [PERIOD_W-1:0] period,
  output logic                wrap
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] step_next;
  logic             lockup_q, lockup_d;

  lfsr_step #(
    .WIDTH(WIDTH),
    .TAPS (TAPS),
    .STEPS(STEPS)
  ) u_step (
    .q     (data_q),
    .q_next(step_next)
  );

  // A zero state never leaves zero, so both a zero load and a zero state are replaced by SEED.
  always_comb begin
    data_d   = data_q;
    lockup_d = 1'b0;
    if (load) begin
      if (init == '0) begin
        data_d   = SEED;
        lockup_d = 1'b1;
      end else begin
        data_d = init;
      end
    end else if (en) begin
      if (data_q == '0) begin
        data_d   = SEED;
        lockup_d = 1'b1;
      end else begin
        data_d = step_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= SEED;
      lockup_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      lockup_q <= lockup_d;
    end
  end

  assign data   = data_q;
  assign lockup = lockup_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0]    start_q, start_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                wrap_q, wrap_d;

  // The start register tracks whatever value data actually took on load, including SEED substitution.
  always_comb begin
    start_d  = start_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    if (load) begin
      start_d  = (init == '0) ? SEED : init;
      period_d = '0;
    end else if (en) begin
      if (period_q != '1) begin
        period_d = period_q + 1'b1;
      end
      wrap_d = (data_d == start_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q  <= SEED;
      period_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      start_q  <= start_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
    end
  end

  assign period = period_q;
  assign wrap   = wrap_q;
`else
  assign period = '0;
  assign wrap   = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: vector table through a scoreboard queue, then hand-written
// sequences for the full period, STEPS=2, zero lockup and asynchronous reset.
module tb_lfsr_gen;

`ifdef LFSR_PERIOD_CNT_EN
  localparam bit PCNT = 1'b1;
`else
  localparam bit PCNT = 1'b0;
`endif
  localparam int EXP_W = 42;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  init = 8'h00;
  logic        load = 1'b0;
  logic        en = 1'b0;

  logic [7:0]  d0_data, d1_data, d2_data;
  logic        d0_lockup, d1_lockup, d2_lockup;
  logic [31:0] d0_period, d1_period, d2_period;
  logic        d0_wrap, d1_wrap, d2_wrap;

  int checks = 0;
  int failures = 0;

  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    logic        load;
    logic        en;
    logic [7:0]  init;
    logic [7:0]  data;
    logic        lockup;
    logic [31:0] period;  // value with the counter built in
    logic        wrap;
  } vec_t;

  vec_t vecs[16];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures);
    $fatal(1, "watchdog");
  end

  lfsr_gen u_d0 (
    .clk(clk), .reset(reset), .init(init), .load(load), .en(en),
    .data(d0_data), .lockup(d0_lockup), .period(d0_period), .wrap(d0_wrap)
  );

  lfsr_gen #(.STEPS(2)) u_d1 (
    .clk(clk), .reset(reset), .init(init), .load(load), .en(en),
    .data(d1_data), .lockup(d1_lockup), .period(d1_period), .wrap(d1_wrap)
  );

  lfsr_gen #(.TAPS(8'h1C)) u_d2 (
    .clk(clk), .reset(reset), .init(init), .load(load), .en(en),
    .data(d2_data), .lockup(d2_lockup), .period(d2_period), .wrap(d2_wrap)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with reset released.
  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    en    = 1'b0;
    init  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data",   64'(d0_data),   64'h01);
    check("rst_lockup", 64'(d0_lockup), 64'h0);
    check("rst_period", 64'(d0_period), 64'h0);
    check("rst_wrap",   64'(d0_wrap),   64'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Driver: apply one vector at a negedge, push expectation, compare after the edge.
  task automatic apply(input int idx);
    logic [EXP_W-1:0] exp_v;
    load = vecs[idx].load;
    en   = vecs[idx].en;
    init = vecs[idx].init;
    exp_q.push_back({vecs[idx].data, vecs[idx].lockup,
                     (PCNT ? vecs[idx].period : 32'd0), vecs[idx].wrap});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    check($sformatf("vec[%0d]", idx), 64'({d0_data, d0_lockup, d0_period, d0_wrap}), 64'(exp_v));
    @(negedge clk);
  endtask

  initial begin
    int first_ret;
    int wrap_cnt;

    vecs[0]  = '{1'b0, 1'b1, 8'h00, 8'h80, 1'b0, 32'd1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 32'd1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 32'd1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 8'h40, 1'b0, 32'd2, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 8'h20, 1'b0, 32'd3, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h10, 1'b0, 32'd4, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 8'h88, 1'b0, 32'd5, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 32'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 32'd0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 8'h10, 8'h10, 1'b0, 32'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 8'h88, 1'b0, 32'd1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 8'h88, 1'b0, 32'd1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'h5A, 8'h5A, 1'b0, 32'd0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 8'h2D, 1'b0, 32'd1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 8'h00, 8'h01, 1'b1, 32'd0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 8'h00, 8'h80, 1'b0, 32'd1, 1'b0};

    // Table phase
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 16; i++) apply(i);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    // Full period from reset, plus STEPS=2 and zero-lockup instances on the same stimulus
    do_reset();
    en = 1'b1;
    first_ret = 0;
    wrap_cnt  = 0;
    for (int c = 1; c <= 255; c++) begin
      @(posedge clk);
      #1;
      if (d0_data == 8'h01 && first_ret == 0) first_ret = c;
      if (d0_wrap) wrap_cnt++;
      if (c == 1) begin
        check("s2_c1",      64'(d1_data),   64'h40);
        check("z_c1_data",  64'(d2_data),   64'h00);
        check("z_c1_lock",  64'(d2_lockup), 64'h0);
      end
      if (c == 2) begin
        check("s2_c2",      64'(d1_data),   64'h10);
        check("z_c2_data",  64'(d2_data),   64'h01);
        check("z_c2_lock",  64'(d2_lockup), 64'h1);
      end
      if (c == 3) begin
        check("z_c3_data",  64'(d2_data),   64'h00);
        check("z_c3_lock",  64'(d2_lockup), 64'h0);
      end
      if (c == 255) begin
        check("full_wrap",   64'(d0_wrap),   64'(PCNT));
        check("full_period", 64'(d0_period), PCNT ? 64'd255 : 64'd0);
      end
      @(negedge clk);
    end
    check("first_return", 64'(first_ret), 64'd255);
    check("wrap_count",   64'(wrap_cnt),  64'(PCNT));
    en = 1'b0;
    @(posedge clk);
    #1;
    check("wrap_drop",   64'(d0_wrap),   64'h0);
    check("hold_data",   64'(d0_data),   64'h01);
    check("hold_period", 64'(d0_period), PCNT ? 64'd255 : 64'd0);
    @(negedge clk);

    // Asynchronous reset mid-sequence
    do_reset();
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_data",   64'(d0_data),   64'h20);
    check("pre_rst_period", 64'(d0_period), PCNT ? 64'd3 : 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_data",   64'(d0_data),   64'h01);
    check("async_lockup", 64'(d0_lockup), 64'h0);
    check("async_period", 64'(d0_period), 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_step", 64'(d0_data), 64'h80);
    check("post_rst_period", 64'(d0_period), PCNT ? 64'd1 : 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
